// File: rtl/array_19_queue_ctrl_if.sv
// Handshake and SRAM-macro signal bundle for the array_19 queue controller.
// The controller side uses the master modport; producer/consumer/macro use slave.
interface array_19_queue_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 512
);
  logic              enq_valid;
  logic              enq_ready;
  logic [WIDTH-1:0]  enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [WIDTH-1:0]  deq_bits;
  logic [ADDR_W+1:0] count;
  logic              mem_W0_en;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic [WIDTH-1:0]  mem_W0_data;
  logic              mem_R0_en;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic [WIDTH-1:0]  mem_R0_data;

  modport master (
    input  enq_valid, enq_bits, deq_ready, mem_R0_data,
    output enq_ready, deq_valid, deq_bits, count,
           mem_W0_en, mem_W0_addr, mem_W0_data, mem_R0_en, mem_R0_addr
  );

  modport slave (
    output enq_valid, enq_bits, deq_ready, mem_R0_data,
    input  enq_ready, deq_valid, deq_bits, count,
           mem_W0_en, mem_W0_addr, mem_W0_data, mem_R0_en, mem_R0_addr
  );
endinterface

// File: rtl/array_19_queue_ctrl.sv
// FIFO controller around a 1R1W SRAM macro with a 2-entry output stage that
// hides the macro's one-cycle read latency; holds up to DEPTH+2 entries.
module array_19_queue_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 512
) (
  input logic                    clock,
  input logic                    reset,
  array_19_queue_ctrl_if.master  q
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        stage_cnt_q, stage_cnt_d;
  logic [WIDTH-1:0]  stage_q [2];
  logic [WIDTH-1:0]  stage_d [2];

  logic       enq_ready;
  logic       enq_fire;
  logic       deq_valid;
  logic       deq_fire;
  logic       rd_issue;
  logic       cap_idx;
  logic [2:0] pending;

  // Read-issue room counts the stage plus any word still in flight from the macro.
  assign pending   = {1'b0, stage_cnt_q} + {2'b00, inflight_q};
  assign enq_ready = !reset && (mem_cnt_q < DEPTH_C);
  assign enq_fire  = q.enq_valid && enq_ready;
  assign deq_valid = (stage_cnt_q != 2'd0);
  assign deq_fire  = deq_valid && q.deq_ready;
  assign rd_issue  = !reset && (mem_cnt_q != '0) && ((pending < 3'd2) || deq_fire);
  // Captured word lands behind whatever survives this cycle's pop.
  assign cap_idx   = stage_cnt_q[1] || (stage_cnt_q[0] && !deq_fire);

  assign q.enq_ready   = enq_ready;
  assign q.deq_valid   = deq_valid;
  assign q.deq_bits    = stage_q[0];
  assign q.count       = (ADDR_W+2)'(mem_cnt_q) + (ADDR_W+2)'(inflight_q)
                       + (ADDR_W+2)'(stage_cnt_q);
  assign q.mem_W0_en   = enq_fire;
  assign q.mem_W0_addr = wr_ptr_q;
  assign q.mem_W0_data = q.enq_bits;
  assign q.mem_R0_en   = rd_issue;
  assign q.mem_R0_addr = rd_ptr_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    wr_ptr_d    = wr_ptr_q + ADDR_W'(enq_fire);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_issue);
    mem_cnt_d   = mem_cnt_q + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(rd_issue);
    inflight_d  = rd_issue;
    stage_cnt_d = stage_cnt_q + 2'(inflight_q) - 2'(deq_fire);
    stage_d     = stage_q;
    if (deq_fire) begin
      stage_d[0] = stage_q[1];
    end
    if (inflight_q) begin
      stage_d[cap_idx] = q.mem_R0_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      stage_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      inflight_q  <= inflight_d;
      stage_cnt_q <= stage_cnt_d;
    end
  end

  // NOTE: stage data is not reset; stage_cnt_q alone says which entries are meaningful.
  always_ff @(posedge clock) begin
    stage_q <= stage_d;
  end
endmodule

// File: tb/tb_array_19_queue_ctrl.sv
// Self-checking bench for array_19_queue_ctrl: SRAM macro model, queue-level
// reference model compared every cycle, plus directed literal checks.
module tb_array_19_queue_ctrl;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int WIDTH  = 512;
  localparam int CAP    = DEPTH + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_19_queue_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) q_if ();

  array_19_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (rst),
    .q     (q_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // SRAM macro: registered read, data meaningless unless a read was issued.
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (q_if.mem_W0_en) sram[q_if.mem_W0_addr] <= q_if.mem_W0_data;
    if (q_if.mem_R0_en) q_if.mem_R0_data <= sram[q_if.mem_R0_addr];
    else                q_if.mem_R0_data <= rand_word();
  end

  // Reference model: the queue contents in order, plus which macro slots hold unread data.
  logic [WIDTH-1:0] mq [$];
  bit slot_full [DEPTH];
  int wr_idx = 0;
  int rd_idx = 0;
  int stall  = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("count", q_if.count, mq.size());
      if (rst) begin
        check("rst_enq_ready", q_if.enq_ready, 0);
        check("rst_w0_en", q_if.mem_W0_en, 0);
        check("rst_r0_en", q_if.mem_R0_en, 0);
        mq.delete();
        foreach (slot_full[i]) slot_full[i] = 1'b0;
        wr_idx = 0;
        rd_idx = 0;
        stall  = 0;
      end else begin
        bit enq_fire, deq_fire;
        enq_fire = q_if.enq_valid && q_if.enq_ready;
        deq_fire = q_if.deq_valid && q_if.deq_ready;
        check("count_max", q_if.count <= CAP, 1);
        if (mq.size() < DEPTH) check("enq_ready_open", q_if.enq_ready, 1);
        else if (mq.size() >= CAP) check("enq_ready_full", q_if.enq_ready, 0);
        check("w0_en", q_if.mem_W0_en, enq_fire);
        if (q_if.mem_W0_en) begin
          check("w0_addr", q_if.mem_W0_addr, wr_idx);
          check("w0_data", q_if.mem_W0_data, q_if.enq_bits);
          check("w0_slot_free", slot_full[q_if.mem_W0_addr], 0);
        end
        if (q_if.mem_R0_en) begin
          check("r0_addr", q_if.mem_R0_addr, rd_idx);
          check("r0_slot_written", slot_full[q_if.mem_R0_addr], 1);
        end
        if (mq.size() == 0) begin
          check("empty_deq_valid", q_if.deq_valid, 0);
          check("empty_r0_en", q_if.mem_R0_en, 0);
        end
        if (q_if.deq_valid) check("deq_nonempty", mq.size() != 0, 1);
        if (deq_fire && mq.size() != 0) check("deq_bits", q_if.deq_bits, mq[0]);
        if (mq.size() != 0 && !q_if.deq_valid) begin
          stall++;
          check("head_latency", stall <= 2, 1);
        end else begin
          stall = 0;
        end
        if (q_if.mem_R0_en) begin
          slot_full[q_if.mem_R0_addr] = 1'b0;
          rd_idx = (rd_idx + 1) % DEPTH;
        end
        if (enq_fire) begin
          mq.push_back(q_if.enq_bits);
          slot_full[q_if.mem_W0_addr] = 1'b1;
          wr_idx = (wr_idx + 1) % DEPTH;
        end
        if (deq_fire && mq.size() != 0) void'(mq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    q_if.enq_valid = 1'b0;
    q_if.deq_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q_if.count == 0 && !q_if.deq_valid) done = 1'b1;
      step();
    end
    check(name, done, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] a5_word;
    int  n;
    bit  acc, seen;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a5_word;
    int  n;
    bit  acc, seen;

    a5_word = {8{64'hA5A5_A5A5_A5A5_A5A5}};
    q_if.enq_valid = 1'b0;
    q_if.enq_bits  = '0;
    q_if.deq_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_count", q_if.count, 0);
    check("reset_deq_valid", q_if.deq_valid, 0);
    check("reset_enq_ready", q_if.enq_ready, 1);
    step();

    // Single word latency: enq T, issue T+1, deq_valid T+3.
    q_if.enq_valid = 1'b1;
    q_if.enq_bits  = a5_word;
    q_if.deq_ready = 1'b1;
    @(negedge clk);
    check("t0_w0_en", q_if.mem_W0_en, 1);
    check("t0_r0_en", q_if.mem_R0_en, 0);
    step();
    q_if.enq_valid = 1'b0;
    @(negedge clk);
    check("t1_r0_en", q_if.mem_R0_en, 1);
    check("t1_count", q_if.count, 1);
    step();
    @(negedge clk);
    check("t2_deq_valid", q_if.deq_valid, 0);
    step();
    @(negedge clk);
    check("t3_deq_valid", q_if.deq_valid, 1);
    check("t3_deq_bits", q_if.deq_bits, a5_word);
    check("t3_count", q_if.count, 1);
    step();
    @(negedge clk);
    check("t4_count", q_if.count, 0);
    check("t4_deq_valid", q_if.deq_valid, 0);
    step();

    // Streaming: one word per cycle, count settles at 3 with no bubbles.
    for (int k = 0; k < 200; k++) begin
      q_if.enq_valid = 1'b1;
      q_if.enq_bits  = WIDTH'(k);
      q_if.deq_ready = 1'b1;
      @(negedge clk);
      if (k >= 3) begin
        check("stream_count", q_if.count, 3);
        check("stream_deq_valid", q_if.deq_valid, 1);
        check("stream_deq_bits", q_if.deq_bits, WIDTH'(k - 3));
      end
      step();
    end
    drain("stream_drain");

    // Fill to capacity with the consumer stalled.
    q_if.deq_ready = 1'b0;
    q_if.enq_valid = 1'b1;
    n = 0;
    q_if.enq_bits = WIDTH'(n);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = q_if.enq_ready;
      step();
      if (acc) begin
        n++;
        q_if.enq_bits = WIDTH'(n);
      end
    end
    @(negedge clk);
    check("full_accepted", n, CAP);
    check("full_count", q_if.count, CAP);
    check("full_enq_ready", q_if.enq_ready, 0);
    step();
    q_if.deq_ready = 1'b1;
    @(negedge clk);
    check("full_pop_valid", q_if.deq_valid, 1);
    check("full_pop_bits", q_if.deq_bits, WIDTH'(0));
    step();
    q_if.deq_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (q_if.enq_ready) seen = 1'b1;
      step();
    end
    check("full_reopen", seen, 1);
    q_if.enq_valid = 1'b0;
    @(negedge clk);
    check("full_refill_count", q_if.count, CAP);
    step();
    drain("full_drain");

    // Random traffic, balanced then producer-heavy so the queue fills and wraps.
    for (int c = 0; c < 12000; c++) begin
      if (c < 10000) begin
        q_if.enq_valid = 1'($urandom_range(0, 1));
        q_if.deq_ready = 1'($urandom_range(0, 1));
      end else begin
        q_if.enq_valid = ($urandom_range(0, 9) < 8);
        q_if.deq_ready = ($urandom_range(0, 9) < 2);
      end
      q_if.enq_bits = rand_word();
      step();
    end
    drain("random_drain");

    // Reset with a read in flight drops all contents.
    q_if.deq_ready = 1'b0;
    q_if.enq_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q_if.enq_bits = WIDTH'(100 + i);
      step();
    end
    q_if.enq_valid = 1'b0;
    repeat (4) step();
    q_if.deq_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_r0_en", q_if.mem_R0_en, 1);
    step();
    q_if.deq_ready = 1'b0;
    q_if.enq_valid = 1'b1;
    q_if.enq_bits  = WIDTH'(32'hDEAD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_if.enq_bits = WIDTH'(1);
    @(negedge clk);
    check("post_rst_deq_valid", q_if.deq_valid, 0);
    check("post_rst_count", q_if.count, 0);
    check("post_rst_enq_ready", q_if.enq_ready, 1);
    step();
    q_if.enq_valid = 1'b0;
    q_if.deq_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (q_if.deq_valid) begin
        seen = 1'b1;
        check("post_rst_bits", q_if.deq_bits, WIDTH'(1));
      end
      step();
    end
    check("post_rst_seen", seen, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_empty_count", q_if.count, 0);
      check("post_rst_empty_valid", q_if.deq_valid, 0);
      step();
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
